// File: rtl/baud_generator_frac.sv
// Runtime-programmable UART baud generator: os_tick / baud_tick / mid_tick from clk.
// Optional fractional-N divisor enabled by defining BAUD_FRAC_EN.
module baud_generator_frac #(
    parameter int CNT_W            = 16,
    parameter int FRAC_W           = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 6,
    parameter int DEFAULT_DIV_FRAC = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [CNT_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    output logic                          os_tick,
    output logic                          baud_tick,
    output logic                          mid_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          cfg_err
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]  DEF_INT  = CNT_W'(DEFAULT_DIV_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_DIV_FRAC);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   PH_PREMID = PH_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0] div_int_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   d_eff;
    logic [CNT_W:0]   period_m1;
    logic             extra;
    logic             restart;
    logic             terminal;

    assign restart = !enable || div_load;

    // Compare at CNT_W+1 bits so an all-ones divisor plus an extra clock cannot wrap.
    assign d_eff     = (div_int_q == '0) ? (CNT_W+1)'(1) : {1'b0, div_int_q};
    assign period_m1 = d_eff + {{CNT_W{1'b0}}, extra} - (CNT_W+1)'(1);
    assign terminal  = ({1'b0, cnt} == period_m1);

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] div_frac_q;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, div_frac_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_frac_q <= DEF_FRAC;
            acc        <= '0;
            extra      <= 1'b0;
        end else begin
            if (div_load) begin
                div_frac_q <= div_frac;
            end
            if (restart) begin
                acc   <= '0;
                extra <= 1'b0;
            end else if (terminal) begin
                acc   <= acc_sum[FRAC_W-1:0];
                extra <= acc_sum[FRAC_W];
            end
        end
    end
`else
    logic unused_frac;

    assign extra       = 1'b0;
    assign unused_frac = ^{div_frac, DEF_FRAC};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_int_q <= DEF_INT;
            cnt       <= '0;
            os_phase  <= '0;
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
            mid_tick  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (div_load) begin
                div_int_q <= div_int;
                cfg_err   <= (div_int == '0);
            end else begin
                cfg_err   <= (div_int_q == '0);
            end

            if (restart) begin
                cnt       <= '0;
                os_phase  <= '0;
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
                mid_tick  <= 1'b0;
            end else if (terminal) begin
                cnt       <= '0;
                os_phase  <= os_phase + PH_W'(1);
                os_tick   <= 1'b1;
                baud_tick <= (os_phase == PH_LAST);
                mid_tick  <= (os_phase == PH_PREMID);
            end else begin
                cnt       <= cnt + CNT_W'(1);
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
                mid_tick  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_generator_frac.sv
// Self-checking bench for baud_generator_frac; period model follows BAUD_FRAC_EN.
module tb_baud_generator_frac;

    localparam int OS = 16;
    localparam int FW = 4;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        os_tick, baud_tick, mid_tick, cfg_err;
    logic [3:0]  os_phase;

    int errors = 0;
    int checks = 0;
    int tick_idx = 0;

    baud_generator_frac dut (
        .clk(clk), .reset(reset), .enable(enable),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .os_tick(os_tick), .baud_tick(baud_tick), .mid_tick(mid_tick),
        .os_phase(os_phase), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Vector {os_tick, baud_tick, mid_tick, cfg_err, os_phase} vs the model.
    task automatic expect_state(input string tag, input bit tick, input int di);
        logic [7:0] obs, exp;
        obs = {os_tick, baud_tick, mid_tick, cfg_err, os_phase};
        exp = {tick, tick && (tick_idx % OS == 0), tick && (tick_idx % OS == OS/2),
               (di == 0), 4'(tick_idx % OS)};
        chk(tag, {24'd0, obs}, {24'd0, exp});
    endtask

    // Assumes the generator was just restarted; checks n oversample periods cycle by cycle.
    task automatic run_periods(input int n, input int di, input int df);
        int d, fe, ext, len;
        d  = (di == 0) ? 1 : di;
        fe = FRAC_ON ? df : 0;
        for (int k = 1; k <= n; k++) begin
            ext = (k == 1) ? 0 : ((k-1)*fe)/(1<<FW) - ((k-2)*fe)/(1<<FW);
            len = d + ext;
            for (int c = 1; c < len; c++) begin
                @(negedge clk);
                expect_state("idle_cycle", 1'b0, di);
            end
            @(negedge clk);
            tick_idx++;
            expect_state("tick_cycle", 1'b1, di);
        end
    endtask

    task automatic do_load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        tick_idx = 0;
        expect_state("after_load", 1'b0, di);
    endtask

    initial begin
        int rdi, rdf, rn;
        #1 reset = 1'b0;
        #11;
        chk("reset_outputs", {24'd0, os_tick, baud_tick, mid_tick, cfg_err, os_phase}, 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        tick_idx = 0;
        run_periods(20, 6, 8);

        // integer mode
        do_load(4, 0);
        run_periods(40, 4, 0);

        // fractional mode
        do_load(4, 8);
        run_periods(24, 4, 8);

        // disable at os_phase 7
        do_load(4, 0);
        run_periods(7, 4, 0);
        chk("phase_before_disable", {28'd0, os_phase}, 32'd7);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tick_idx = 0;
            expect_state("disabled", 1'b0, 4);
        end
        enable = 1'b1;
        run_periods(20, 4, 0);

        // reload mid-period
        do_load(4, 0);
        run_periods(5, 4, 0);
        @(negedge clk);
        expect_state("mid_period", 1'b0, 4);
        do_load(10, 0);
        tick_idx = 0;
        run_periods(20, 10, 0);

        // load while disabled still updates the divisor
        enable = 1'b0;
        @(negedge clk);
        do_load(5, 0);
        enable = 1'b1;
        run_periods(10, 5, 0);

        // illegal divisor then recovery
        do_load(0, 0);
        run_periods(20, 0, 0);
        do_load(3, 0);
        run_periods(20, 3, 0);

        // randomized divisors
        repeat (5) begin
            rdi = $urandom_range(0, 12);
            rdf = $urandom_range(0, 15);
            rn  = $urandom_range(10, 36);
            do_load(rdi, rdf);
            run_periods(rn, rdi, rdf);
        end

        // async reset between edges, with os_tick and cfg_err high
        do_load(0, 0);
        run_periods(5, 0, 0);
        chk("tick_before_reset", {31'd0, os_tick}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_clear", {24'd0, os_tick, baud_tick, mid_tick, cfg_err, os_phase}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick_idx = 0;
        run_periods(24, 6, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
